// File: rtl/m_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: state encoding and
// parameter limits.
package m_dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_LOG2_DEFAULT = 6;
    localparam int LATENCY_MIN        = 1;
    localparam int LATENCY_MAX        = 15;

endpackage

// File: rtl/m_dmem_array.sv
// Word-organised data storage: asynchronous read, synchronous write with
// per-byte enables. Contents are not affected by reset.
module m_dmem_array #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  w_clk,
    input  logic                  w_we,
    input  logic [DEPTH_LOG2-1:0] w_idx,
    input  logic [31:0]           w_wdata,
    input  logic [3:0]            w_wstrb,
    output logic [31:0]           w_rdata
);

    logic [31:0] mem [2**DEPTH_LOG2] = '{default: '0};

    always_ff @(posedge w_clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_rdata = mem[w_idx];

endmodule

// File: rtl/m_dmem_responder.sv
// Valid/ready load/store responder with fixed response latency and
// misaligned / out-of-range error reporting.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, counting down the latency
// RESP  | response held until the initiator accepts it
module m_dmem_responder
    import m_dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int LATENCY    = 2
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_write,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    input  logic [3:0]  w_req_wstrb,
    output logic        w_resp_valid,
    input  logic        w_resp_ready,
    output logic [31:0] w_resp_rdata,
    output logic        w_resp_err
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("m_dmem_responder: LATENCY must be within 1..15");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept, commit, mem_we;
    logic        src_wr, src_err;
    logic [31:0] src_addr, src_wdata, mem_rdata;
    logic [3:0]  src_wstrb;

    assign w_req_ready  = (state_q == IDLE);
    assign w_resp_valid = (state_q == RESP);
    assign w_resp_rdata = rdata_q;
    assign w_resp_err   = err_q;
    assign accept       = w_req_valid & w_req_ready;

    // With LATENCY == 1 the commit happens on the accept edge, before the
    // request registers hold anything, so the live inputs are used there.
    assign src_wr    = (state_q == IDLE) ? w_req_write : wr_q;
    assign src_addr  = (state_q == IDLE) ? w_req_addr  : addr_q;
    assign src_wdata = (state_q == IDLE) ? w_req_wdata : wdata_q;
    assign src_wstrb = (state_q == IDLE) ? w_req_wstrb : wstrb_q;
    assign src_err   = (src_addr[1:0] != 2'b00) | (src_addr[31:DEPTH_LOG2+2] != '0);

    assign mem_we = commit & ~w_rst & src_wr & ~src_err & (|src_wstrb);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (w_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= w_req_write;
                addr_q  <= w_req_addr;
                wdata_q <= w_req_wdata;
                wstrb_q <= w_req_wstrb;
            end
            if (commit) begin
                rdata_q <= (!src_wr && !src_err) ? mem_rdata : 32'h0;
                err_q   <= src_err;
            end else if (w_resp_valid && w_resp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    m_dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .w_clk   (w_clk),
        .w_we    (mem_we),
        .w_idx   (src_addr[DEPTH_LOG2+1:2]),
        .w_wdata (src_wdata),
        .w_wstrb (src_wstrb),
        .w_rdata (mem_rdata)
    );

endmodule
